alu32_arbiter: RTL
==================

// Module: alu32_arbiter
// PURPOSE
//   Shares one alu32 instance between two requesters (r0, r1) using round-robin arbitration.
//   Each requester uses a valid/ready request channel and a valid/ready response channel.
//   Operands are captured on accept and the result is registered, so callers never hold
//   operands. Sits between multi-cycle clients (e.g. address-gen, debug unit) and the ALU.
// PARAMETERS
//   WIDTH        32  operand/result width; passed to the internal alu32
//   EXEC_CYCLES  1   cycles spent in EXEC before the result is captured (>=1)
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge
//   rst_n        in   1      reset, asynchronous, active-low
//   r0_valid     in   1      r0 request valid
//   r0_ready     out  1      r0 request accepted this cycle when r0_valid & r0_ready
//   r0_a, r0_b   in   WIDTH  r0 operands
//   r0_ctrl      in   3      r0 ALUControl code, passed unchanged to alu32
//   r0_rsp_valid out  1      r0 result available
//   r0_rsp_ready in   1      r0 consumes result when r0_rsp_valid & r0_rsp_ready
//   r0_result    out  WIDTH  r0 registered result
//   r1_*         --   --     identical set for requester 1
//   busy         out  1      high in any state other than IDLE
//   grant        out  1      owner of the current/last transaction (0=r0, 1=r1)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, all *_ready/*_rsp_valid=0, results=0, busy=0,
//     grant=0, last-grant pointer=1 (r0 wins the first contention), exec counter=0.
//   - FSM: IDLE -> EXEC on accept; EXEC -> RESP when exec counter reaches EXEC_CYCLES-1;
//     RESP -> IDLE on response handshake of the owner. No other transitions.
//   - IDLE: the arbiter picks a winner combinationally. If only one requester is valid, it
//     wins. If both are valid, the winner is the one not equal to the last-grant pointer.
//     Only the winner's *_ready is driven high (Moore on state, Mealy on valid). The loser's
//     ready stays 0.
//   - Accept edge: latch a, b, ctrl and owner; set grant=owner and the pointer=owner.
//   - EXEC: the alu32 is fed only from the latched operands. The counter increments each
//     cycle. On the edge ending the last EXEC cycle, the alu32 output goes into the owner's
//     *_result register.
//   - RESP: the owner's *_rsp_valid=1. Its *_result is stable until the handshake. Both
//     *_ready=0. The non-owner's rsp_valid=0 and its result register keeps its old value.
//   - Latency: accept on edge k -> rsp_valid high from edge k+EXEC_CYCLES. With the
//     default this is 1 cycle after accept.
//   - After the response handshake, the FSM returns to IDLE. The earliest next accept is
//     the following edge, which gives one bubble per transaction.
//   - Arithmetic: full WIDTH, wraps modulo 2^WIDTH. Opcode semantics belong to alu32.
//     Unknown codes are forwarded and the alu32 output is returned as-is.
//   - Valid dropped in IDLE before ready: nothing happens. A requester holds valid and
//     operands until accepted.
//   - rsp_ready asserted with rsp_valid low is ignored.
//   - Reset mid-EXEC or mid-RESP: the transaction is discarded and no response is ever
//     produced for it.
// TESTING
//   1 r0 only: a=10,b=10,ctrl=000 -> r0_ready=1 in IDLE; r0_rsp_valid one cycle later,
//     r0_result=20; r1_rsp_valid stays 0.
//   2 Both valid after reset: r0 a=10,b=3,ctrl=001 and r1 a=5,b=7,ctrl=000 -> r0 first
//     (result 7, grant=0), then r1 (result 12, grant=1).
//   3 Back-pressure: hold r0_rsp_ready=0 for 5 cycles -> rsp_valid and result are held,
//     busy=1, and both *_ready=0 throughout.
//   4 Both held valid for 4 transactions with rsp_ready=1 -> grant sequence 0,1,0,1 and
//     one idle bubble between each.
//   5 Assert rst_n=0 during EXEC -> all outputs 0 immediately, no response after release;
//     a fresh r1 request (a=1,b=2,ctrl=000) then returns 3.
//   6 Wrap: a=0,b=1,ctrl=001 -> 0xFFFFFFFF; a=0xFFFFFFFF,b=1,ctrl=000 -> 0x00000000.

Source files
------------

// File: rtl/alu32_arbiter.sv
// alu32_arbiter: round-robin sharing of one registered alu32 between two valid/ready requesters
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] y
);
    // add, sub, and, or, signed set-less-than; unused codes yield zero
    always_comb begin
        case (ctrl)
            3'b000:  y = a + b;
            3'b001:  y = a - b;
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b101:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end
endmodule

module alu32_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_ctrl,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_result,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_ctrl,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_result,
    output logic             busy,
    output logic             grant
);
    localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [WIDTH-1:0] alu_y;
    logic             win;
    logic             rsp_hs;

    alu32 #(.WIDTH(WIDTH)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .ctrl (ctrl_q),
        .y    (alu_y)
    );

    // winner selection, handshakes and Moore/Mealy outputs
    always_comb begin
        win          = (r0_valid & r1_valid) ? ~ptr_q : r1_valid;
        r0_ready     = rst_n & (state_q == IDLE) & r0_valid & ~win;
        r1_ready     = rst_n & (state_q == IDLE) & r1_valid & win;
        r0_rsp_valid = (state_q == RESP) & ~grant_q;
        r1_rsp_valid = (state_q == RESP) & grant_q;
        rsp_hs       = grant_q ? r1_rsp_ready : r0_rsp_ready;
        busy         = state_q != IDLE;
        grant        = grant_q;
        r0_result    = res0_q;
        r1_result    = res1_q;
    end

    // next state: capture on accept, count EXEC, store result, release on owner handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        case (state_q)
            IDLE: begin
                if (r0_ready | r1_ready) begin
                    state_d = EXEC;
                    a_d     = win ? r1_a : r0_a;
                    b_d     = win ? r1_b : r0_b;
                    ctrl_d  = win ? r1_ctrl : r0_ctrl;
                    grant_d = win;
                    ptr_d   = win;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    res0_d  = grant_q ? res0_q : alu_y;
                    res1_d  = grant_q ? alu_y : res1_q;
                end
            end
            RESP: state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end
endmodule
